led_cmd_rx: RTL and testbench
=============================

LED_CMD_RX -- requirements
Module: led_cmd_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, serial bit rate; CLKS_PER_BIT = CLK_FREQ / BAUD (integer division).
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port led_mask  output  8  LED enable mask for the downstream blinker.
REQ-007 SHALL have port period_div  output  8  blink-rate divisor for the downstream blinker (half period = CLK_FREQ / period_div).
REQ-008 SHALL have port cmd_valid  output  1  one-cycle pulse on every accepted command.
REQ-009 SHALL have port err  output  1  one-cycle pulse on a framing, parity or argument error.

Function
REQ-010 SHALL pass rx through a 2-flop synchroniser before any use.
REQ-011 SHALL implement the receive FSM IDLE -> START -> DATA -> STOP -> IDLE, with frame format 8N1 and data LSB first.
REQ-012 IDLE SHALL leave to START on a synchronised high-to-low transition.
REQ-013 START SHALL re-sample after CLKS_PER_BIT/2 cycles: a low sample goes to DATA; a high sample is a glitch and returns to IDLE with no error.
REQ-014 DATA SHALL sample one bit every CLKS_PER_BIT cycles, 8 bits total, using a 3-bit bit index and a baud counter that wraps to 0.
REQ-015 STOP SHALL sample once after CLKS_PER_BIT cycles: a high sample delivers the byte; a low sample pulses err, discards the byte and returns to IDLE.
REQ-016 A line held low (break) SHALL NOT start a new frame until rx has returned high.
REQ-017 SHALL implement the parser FSM WAIT_CMD / WAIT_ARG. In WAIT_CMD, byte 0x4C ('L') or 0x50 ('P') is latched as the pending header and moves to WAIT_ARG; any other byte is silently ignored.
REQ-018 In WAIT_ARG after 'L', the next byte SHALL be written to led_mask.
REQ-019 In WAIT_ARG after 'P', a nonzero byte SHALL be written to period_div; a zero byte SHALL leave period_div unchanged and pulse err.
REQ-020 The parser SHALL return to WAIT_CMD after any argument byte, accepted or rejected.
REQ-021 An output update and its cmd_valid pulse SHALL occur exactly 1 clk after the stop-bit sample that completed the argument byte.
REQ-022 A receive error SHALL NOT reset the parser state; the next good byte is interpreted in the current parser state.
REQ-023 cmd_valid and err SHALL never assert in the same cycle.

Reset
REQ-024 While rst_n is low at a clk edge, the block SHALL set: receive FSM = IDLE, parser = WAIT_CMD, all counters = 0, synchroniser flops = 1, led_mask = 8'h81, period_div = 8'd5, cmd_valid = 0, err = 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no output change beyond the reset values; the first frame after reset begins only on a new falling edge.

Configuration
REQ-026 Macro LED_CMD_PARITY_EN SHALL select the frame format.
REQ-027 With LED_CMD_PARITY_EN defined, the frame SHALL be 8E1 with a PARITY state between DATA and STOP; a parity mismatch pulses err at the stop sample and discards the byte.
REQ-028 Without LED_CMD_PARITY_EN, the frame SHALL be 8N1 and no parity logic SHALL exist.

Structure
REQ-029 Package led_cmd_pkg SHALL hold the header constants CMD_LED = 8'h4C and CMD_PER = 8'h50, the reset constants LED_MASK_RST = 8'h81 and PERIOD_DIV_RST = 8'd5, and both FSM state enums.
REQ-030 The receive FSM SHALL be a sub-module uart_rx (ports: clk, rst_n, rx, data[7:0], data_valid, frame_err), and led_cmd_rx SHALL contain the parser and output registers.

Verification (CLK_FREQ = 1_000_000, BAUD = 100_000, i.e. 10 clk/bit)
REQ-031 Reset released, rx idle -> led_mask = 8'h81, period_div = 5, cmd_valid = 0 and err = 0 for 1000 cycles.
REQ-032 Send 0x4C then 0xA5 -> led_mask = 8'hA5 and a single cmd_valid pulse 1 clk after the second stop-bit sample.
REQ-033 Send 0x50 0x00, then 0x50 0x0A -> first pair: err pulse, period_div stays 5; second pair: period_div = 10 with cmd_valid.
REQ-034 Send 0x4C, then a frame with stop bit = 0, then 0x3C -> err pulse on the bad frame; led_mask = 8'h3C.
REQ-035 A 3-clk low glitch on rx, then 0x41, then 0x4C 0xFF -> no err, 0x41 ignored; led_mask = 8'hFF.
REQ-036 rst_n pulsed low during bit 4 of the argument byte after 0x4C -> outputs return to reset values, and the following 0xFF is ignored while the parser is in WAIT_CMD.

Source files
------------

// File: rtl/led_cmd_pkg.sv
// Shared constants and FSM state types for the LED command receiver.
// LED_CMD_PARITY_EN adds the parity state to the receive FSM (8E1 framing).
package led_cmd_pkg;

  localparam logic [7:0] CMD_LED        = 8'h4C;
  localparam logic [7:0] CMD_PER        = 8'h50;
  localparam logic [7:0] LED_MASK_RST   = 8'h81;
  localparam logic [7:0] PERIOD_DIV_RST = 8'd5;

`ifdef LED_CMD_PARITY_EN
  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop
  } rx_state_e;
`else
  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;
`endif

  typedef enum logic {
    PsWaitCmd,
    PsWaitArg
  } parser_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART byte receiver: 8N1 by default, 8E1 when LED_CMD_PARITY_EN is defined.
// data_valid / frame_err are registered one-cycle pulses issued at the stop-bit sample.
module uart_rx
  import led_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]      warm_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            data_valid_q, data_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            stop_ok;
`ifdef LED_CMD_PARITY_EN
  logic            par_q, par_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef LED_CMD_PARITY_EN
    par_d        = par_q;
    stop_ok      = rx_sync_q && (par_q == ^shift_q);
`else
    stop_ok      = rx_sync_q;
`endif
    unique case (state_q)
      RxIdle: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        // rx_prev_q stays low until the synchroniser holds real line data,
        // so a line that is low out of reset never looks like a start edge.
        if (rx_prev_q && !rx_sync_q) state_d = RxStart;
      end
      RxStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef LED_CMD_PARITY_EN
            state_d = RxParity;
`else
            state_d = RxStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef LED_CMD_PARITY_EN
      RxParity: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          par_d   = rx_sync_q;
          state_d = RxStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      RxStop: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = RxIdle;
          if (stop_ok) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b0;
      warm_q       <= '0;
      state_q      <= RxIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef LED_CMD_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
      rx_prev_q    <= (warm_q == 2'd2) ? rx_sync_q : 1'b0;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef LED_CMD_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/led_cmd_rx.sv
// Two-byte serial command parser ('L' mask / 'P' divisor) driving the LED blinker settings.
// Frame format follows LED_CMD_PARITY_EN in uart_rx.
module led_cmd_rx
  import led_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] led_mask,
  output logic [7:0] period_div,
  output logic       cmd_valid,
  output logic       err
);

  logic [7:0]    rx_data;
  logic          rx_valid, rx_ferr;
  parser_state_e ps_q, ps_d;
  logic [7:0]    hdr_q, hdr_d;
  logic [7:0]    led_mask_q, led_mask_d;
  logic [7:0]    period_div_q, period_div_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          err_q, err_d;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_uart_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (rx_data),
    .data_valid(rx_valid),
    .frame_err (rx_ferr)
  );

  // Receive errors pulse err but leave the parser where it is.
  always_comb begin
    ps_d         = ps_q;
    hdr_d        = hdr_q;
    led_mask_d   = led_mask_q;
    period_div_d = period_div_q;
    cmd_valid_d  = 1'b0;
    err_d        = rx_ferr;
    if (rx_valid) begin
      unique case (ps_q)
        PsWaitCmd: begin
          if (rx_data == CMD_LED || rx_data == CMD_PER) begin
            hdr_d = rx_data;
            ps_d  = PsWaitArg;
          end
        end
        PsWaitArg: begin
          ps_d = PsWaitCmd;
          if (hdr_q == CMD_LED) begin
            led_mask_d  = rx_data;
            cmd_valid_d = 1'b1;
          end else if (rx_data != 8'd0) begin
            period_div_d = rx_data;
            cmd_valid_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ps_d = PsWaitCmd;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_q         <= PsWaitCmd;
      hdr_q        <= '0;
      led_mask_q   <= LED_MASK_RST;
      period_div_q <= PERIOD_DIV_RST;
      cmd_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ps_q         <= ps_d;
      hdr_q        <= hdr_d;
      led_mask_q   <= led_mask_d;
      period_div_q <= period_div_d;
      cmd_valid_q  <= cmd_valid_d;
      err_q        <= err_d;
    end
  end

  assign led_mask   = led_mask_q;
  assign period_div = period_div_q;
  assign cmd_valid  = cmd_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_led_cmd_rx.sv
// Randomized self-checking bench for led_cmd_rx against a byte-level command model.
module tb_led_cmd_rx;

  localparam int unsigned ClkFreq = 1_000_000;
  localparam int unsigned Baud    = 100_000;
  localparam int unsigned Cpb     = ClkFreq / Baud;
`ifdef LED_CMD_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  // Stop bit occupies [StopOff, StopOff+Cpb) cycles from the start edge; the
  // update lands one clock after a sample taken inside that bit.
  localparam int StopOff = (FrameBits - 1) * int'(Cpb);
  localparam int LatLo   = StopOff + 1;
  localparam int LatHi   = StopOff + int'(Cpb) + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] led_mask, period_div;
  logic       cmd_valid, err;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int cv_cnt = 0;
  int err_cnt = 0;
  int last_pulse = 0;

  // Byte-level reference model of the command protocol.
  logic [7:0] m_led = 8'h81;
  logic [7:0] m_per = 8'd5;
  logic [7:0] m_hdr = 8'h00;
  logic       m_pend = 1'b0;

  logic [7:0] last_led = 8'h00;
  logic [7:0] last_per = 8'h00;
  logic       rst_d = 1'b0;

  led_cmd_rx #(
    .CLK_FREQ(ClkFreq),
    .BAUD    (Baud)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .led_mask  (led_mask),
    .period_div(period_div),
    .cmd_valid (cmd_valid),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cmd_valid || err) begin
      check_eq("valid_err_exclusive", int'(cmd_valid & err), 0);
      last_pulse = cyc;
      if (cmd_valid) begin
        cv_cnt++;
        check_eq("led_at_valid", int'(led_mask), int'(m_led));
        check_eq("per_at_valid", int'(period_div), int'(m_per));
      end
      if (err) err_cnt++;
    end
    if (rst_n && rst_d && (led_mask != last_led || period_div != last_per))
      check_eq("update_with_valid", int'(cmd_valid), 1);
    last_led = led_mask;
    last_per = period_div;
    rst_d    = rst_n;
  end

  task automatic model_reset();
    m_led  = 8'h81;
    m_per  = 8'd5;
    m_hdr  = 8'h00;
    m_pend = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic good,
                            output logic cv, output logic er);
    cv = 1'b0;
    er = 1'b0;
    if (!good) begin
      er = 1'b1;
    end else if (!m_pend) begin
      if (b == 8'h4C || b == 8'h50) begin
        m_pend = 1'b1;
        m_hdr  = b;
      end
    end else begin
      m_pend = 1'b0;
      if (m_hdr == 8'h4C) begin
        m_led = b;
        cv    = 1'b1;
      end else if (b != 8'h00) begin
        m_per = b;
        cv    = 1'b1;
      end else begin
        er = 1'b1;
      end
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (Cpb) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_led"}, int'(led_mask), int'(m_led));
    check_eq({tag, "_per"}, int'(period_div), int'(m_per));
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int gap_bits);
    int   fs, cv0, er0, off;
    logic exp_cv, exp_er;
    cv0 = cv_cnt;
    er0 = err_cnt;
    model_byte(b, stop_ok, exp_cv, exp_er);
    @(posedge clk);
    #1;
    fs = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef LED_CMD_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_ok);
    idle_cycles(gap_bits * int'(Cpb));
    check_eq("cmd_valid_count", cv_cnt - cv0, int'(exp_cv));
    check_eq("err_count", err_cnt - er0, int'(exp_er));
    check_outputs("frame");
    if (exp_cv || exp_er) begin
      off = last_pulse - fs;
      check_eq("pulse_latency_in_stop_bit", (off >= LatLo && off <= LatHi) ? LatLo : off, LatLo);
    end
  endtask

  task automatic send_glitch(input int low_clks);
    int er0;
    er0 = err_cnt;
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (low_clks) @(posedge clk);
    #1;
    idle_cycles(2 * int'(Cpb));
    check_eq("glitch_no_err", err_cnt - er0, 0);
  endtask

  initial begin
    int bad_idle, cv0, er0, r, gap;
    logic [7:0] b;
    logic       good;

    // Reset and idle
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_outputs("reset");
    check_eq("reset_cmd_valid", int'(cmd_valid), 0);
    check_eq("reset_err", int'(err), 0);
    bad_idle = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (led_mask != 8'h81 || period_div != 8'd5 || cmd_valid || err) bad_idle++;
    end
    check_eq("idle_1000_stable", bad_idle, 0);
    #1;

    // Directed command sequences
    send_frame(8'h4C, 1'b1, 2);
    send_frame(8'hA5, 1'b1, 2);
    send_frame(8'h50, 1'b1, 2);
    send_frame(8'h00, 1'b1, 2);
    send_frame(8'h50, 1'b1, 2);
    send_frame(8'h0A, 1'b1, 2);
    send_frame(8'h4C, 1'b1, 2);
    send_frame(8'h12, 1'b0, 2);
    send_frame(8'h3C, 1'b1, 2);
    send_glitch(3);
    send_frame(8'h41, 1'b1, 2);
    send_frame(8'h4C, 1'b1, 2);
    send_frame(8'hFF, 1'b1, 2);

    // Reset during bit 4 of an argument byte (0xF8: no falling edge after bit 3)
    send_frame(8'h4C, 1'b1, 2);
    cv0 = cv_cnt;
    er0 = err_cnt;
    b   = 8'hF8;
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_outputs("mid_frame_reset");
    repeat (Cpb - 6) @(posedge clk);
    #1;
    for (int i = 5; i < 8; i++) drive_bit(b[i]);
`ifdef LED_CMD_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(1'b1);
    idle_cycles(2 * int'(Cpb));
    check_eq("abandoned_frame_no_valid", cv_cnt - cv0, 0);
    check_eq("abandoned_frame_no_err", err_cnt - er0, 0);
    send_frame(8'hFF, 1'b1, 2);

    // Randomized command stream
    for (int n = 0; n < 70; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2: b = 8'h4C;
        3, 4:    b = 8'h50;
        5:       b = 8'h00;
        default: b = 8'($urandom_range(0, 255));
      endcase
      good = ($urandom_range(0, 9) != 0);
      gap  = int'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) send_glitch(int'($urandom_range(1, 3)));
      send_frame(b, good, gap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
